// File: rtl/drbg_keystream_buffer.sv
// Seeds hash_drbg from an entropy source, buffers its 256-bit outputs
// and serializes them downstream as 32-bit keystream words.
module drbg_keystream_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic [255:0] ent_data,
    input  logic         ent_valid,
    output logic         ent_ready,

    output logic [255:0] entropy,
    output logic         update,
    input  logic         init_ready,
    input  logic         do_reseed,
    output logic         next,
    input  logic         next_ready,
    input  logic [255:0] random_bits,

    output logic [31:0]  ks_word,
    output logic         ks_valid,
    input  logic         ks_ready,

    output logic         seeded,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] ALMOST = (AW+1)'(DEPTH - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        S_SEED,
        S_UPDATE,
        S_WAIT_INIT,
        S_RUN
    } state_t;

    state_t state;
    logic   init_q;

    logic [255:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill;
    logic [2:0]    idx;

    logic push;
    logic drop;
    logic rd_fire;
    logic pop;
    logic space;
    logic init_rise;

    always_comb begin
        push      = next_ready && (fill < FULL);
        drop      = next_ready && (fill == FULL);
        rd_fire   = ks_valid && ks_ready;
        pop       = rd_fire && (idx == 3'd7);
        init_rise = init_ready && !init_q;
        // Withhold the request when the only free slot is being filled now.
        space     = (fill < ALMOST) ||
                    ((fill == ALMOST) && !next_ready);
    end

    assign ks_valid = (fill != '0);
    assign ks_word  = ks_valid ? mem[rd_ptr][{idx, 5'd0} +: 32] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_SEED;
            init_q    <= 1'b0;
            ent_ready <= 1'b0;
            entropy   <= '0;
            update    <= 1'b0;
            next      <= 1'b0;
            seeded    <= 1'b0;
        end else begin
            init_q <= init_ready;
            update <= 1'b0;
            unique case (state)
                S_SEED: begin
                    if (ent_valid && ent_ready) begin
                        entropy   <= ent_data;
                        update    <= 1'b1;
                        ent_ready <= 1'b0;
                        state     <= S_UPDATE;
                    end else begin
                        ent_ready <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    state <= S_WAIT_INIT;
                end
                S_WAIT_INIT: begin
                    if (init_rise) begin
                        seeded <= 1'b1;
                        next   <= space;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (do_reseed) begin
                        next      <= 1'b0;
                        ent_ready <= 1'b1;
                        state     <= S_SEED;
                    end else begin
                        next <= space;
                    end
                end
            endcase
        end
    end

    // Payload storage carries no reset; fill gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= random_bits;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                idx <= idx + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: tb/tb_drbg_keystream_buffer.sv
// Directed vector bench for drbg_keystream_buffer (DEPTH = 2):
// seeding, serialization, backpressure/overflow, reseed, reset mid-stream.
module tb_drbg_keystream_buffer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] ent_data;
    logic         ent_valid;
    logic         ent_ready;
    logic [255:0] entropy;
    logic         update;
    logic         init_ready;
    logic         do_reseed;
    logic         next;
    logic         next_ready;
    logic [255:0] random_bits;
    logic [31:0]  ks_word;
    logic         ks_valid;
    logic         ks_ready;
    logic         seeded;
    logic         overflow;

    always #5 clk = ~clk;

    drbg_keystream_buffer #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ent_data    (ent_data),
        .ent_valid   (ent_valid),
        .ent_ready   (ent_ready),
        .entropy     (entropy),
        .update      (update),
        .init_ready  (init_ready),
        .do_reseed   (do_reseed),
        .next        (next),
        .next_ready  (next_ready),
        .random_bits (random_bits),
        .ks_word     (ks_word),
        .ks_valid    (ks_valid),
        .ks_ready    (ks_ready),
        .seeded      (seeded),
        .overflow    (overflow)
    );

    typedef struct {
        logic         ev;
        logic         ir;
        logic         rs;
        logic         nr;
        logic         kr;
        logic [255:0] ed;
        logic [255:0] rb;
        logic         er;
        logic         up;
        logic         nx;
        logic         kv;
        logic [31:0]  kw;
        logic         sd;
        logic         ov;
        logic [255:0] ent;
    } vec_t;

    vec_t tbl[$];
    int   n_applied = 0;
    int   n_miscmp  = 0;

    logic [255:0] rb1, rb2, rb3, rb4, rb5, rb6, ed2, ed3;

    // Word k of the block equals base + k + 1.
    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) begin
            r[32*k +: 32] = base + 32'(k) + 32'd1;
        end
        return r;
    endfunction

    task automatic add(
        input logic ev, ir, rs, nr, kr,
        input logic [255:0] ed, rb,
        input logic er, up, nx, kv,
        input logic [31:0] kw,
        input logic sd, ov,
        input logic [255:0] ent
    );
        vec_t t;
        t.ev = ev; t.ir = ir; t.rs = rs; t.nr = nr; t.kr = kr;
        t.ed = ed; t.rb = rb;
        t.er = er; t.up = up; t.nx = nx; t.kv = kv; t.kw = kw;
        t.sd = sd; t.ov = ov; t.ent = ent;
        tbl.push_back(t);
    endtask

    task automatic check(
        input string name, input int vi,
        input logic [255:0] act, input logic [255:0] exp
    );
        n_applied++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s vec %0d: got %0h expected %0h",
                     name, vi, act, exp);
        end
    endtask

    task automatic check_all(input int vi, input vec_t t);
        check("ent_ready", vi, 256'(ent_ready), 256'(t.er));
        check("update",    vi, 256'(update),    256'(t.up));
        check("next",      vi, 256'(next),      256'(t.nx));
        check("ks_valid",  vi, 256'(ks_valid),  256'(t.kv));
        check("ks_word",   vi, 256'(ks_word),   256'(t.kw));
        check("seeded",    vi, 256'(seeded),    256'(t.sd));
        check("overflow",  vi, 256'(overflow),  256'(t.ov));
        check("entropy",   vi, entropy,         t.ent);
    endtask

    task automatic drive_idle();
        ent_valid   = 1'b0;
        ent_data    = '0;
        init_ready  = 1'b0;
        do_reseed   = 1'b0;
        next_ready  = 1'b0;
        random_bits = '0;
        ks_ready    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t z;
        rb1 = mk(32'h000);
        rb2 = mk(32'h100);
        rb3 = mk(32'h200);
        rb4 = mk(32'h300);
        rb5 = mk(32'h400);
        rb6 = mk(32'h500);
        ed2 = {8{32'hC0DE_F00D}};
        ed3 = {4{64'h0123_4567_89AB_CDEF}};

        // ev ir rs nr kr | ed rb | er up nx kv kw | sd ov ent
        add(1'b0,1'b0,1'b0,1'b0,1'b0, '0,'0, 1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,'0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0, '0,'0, 1'b0,1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0,'0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, '0,'0, 1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,'0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, '0,'0, 1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,'0);
        add(1'b0,1'b0,1'b0,1'b0,1'b0, '0,'0, 1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,'0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0, '0,'0, 1'b0,1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,'0);
        add(1'b0,1'b1,1'b0,1'b1,1'b1, '0,rb1, 1'b0,1'b0,1'b1,1'b1,32'h1, 1'b1,1'b0,'0);
        for (int k = 1; k < 8; k++)
            add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b0,1'b0,1'b1,1'b1,32'(k+1), 1'b1,1'b0,'0);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b0,1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,'0);
        add(1'b0,1'b0,1'b0,1'b1,1'b0, '0,rb2, 1'b0,1'b0,1'b1,1'b1,32'h101, 1'b1,1'b0,'0);
        add(1'b0,1'b0,1'b0,1'b1,1'b0, '0,rb3, 1'b0,1'b0,1'b0,1'b1,32'h101, 1'b1,1'b0,'0);
        add(1'b0,1'b0,1'b0,1'b1,1'b0, '0,rb4, 1'b0,1'b0,1'b0,1'b1,32'h101, 1'b1,1'b1,'0);
        for (int k = 1; k < 8; k++)
            add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b0,1'b0,1'b0,1'b1,32'(32'h100+k+1), 1'b1,1'b1,'0);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b0,1'b0,1'b0,1'b1,32'h201, 1'b1,1'b1,'0);
        add(1'b0,1'b0,1'b0,1'b0,1'b0, '0,'0, 1'b0,1'b0,1'b1,1'b1,32'h201, 1'b1,1'b1,'0);
        add(1'b0,1'b0,1'b1,1'b0,1'b1, '0,'0, 1'b1,1'b0,1'b0,1'b1,32'h202, 1'b1,1'b1,'0);
        add(1'b0,1'b0,1'b1,1'b0,1'b1, '0,'0, 1'b1,1'b0,1'b0,1'b1,32'h203, 1'b1,1'b1,'0);
        add(1'b1,1'b0,1'b0,1'b0,1'b1, ed2,'0, 1'b0,1'b1,1'b0,1'b1,32'h204, 1'b1,1'b1,ed2);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b0,1'b0,1'b0,1'b1,32'h205, 1'b1,1'b1,ed2);
        add(1'b0,1'b1,1'b0,1'b0,1'b1, '0,'0, 1'b0,1'b0,1'b1,1'b1,32'h206, 1'b1,1'b1,ed2);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b0,1'b0,1'b1,1'b1,32'h207, 1'b1,1'b1,ed2);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b0,1'b0,1'b1,1'b1,32'h208, 1'b1,1'b1,ed2);
        add(1'b0,1'b0,1'b0,1'b1,1'b1, '0,rb5, 1'b0,1'b0,1'b0,1'b1,32'h401, 1'b1,1'b1,ed2);
        add(1'b0,1'b0,1'b1,1'b1,1'b0, '0,rb6, 1'b1,1'b0,1'b0,1'b1,32'h401, 1'b1,1'b1,ed2);
        for (int k = 1; k < 8; k++)
            add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b1,1'b0,1'b0,1'b1,32'(32'h400+k+1), 1'b1,1'b1,ed2);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b1,1'b0,1'b0,1'b1,32'h501, 1'b1,1'b1,ed2);
        for (int k = 1; k < 8; k++)
            add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b1,1'b0,1'b0,1'b1,32'(32'h500+k+1), 1'b1,1'b1,ed2);
        add(1'b0,1'b0,1'b0,1'b0,1'b1, '0,'0, 1'b1,1'b0,1'b0,1'b0,32'h0, 1'b1,1'b1,ed2);

        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        z.er = 1'b0; z.up = 1'b0; z.nx = 1'b0; z.kv = 1'b0;
        z.kw = '0; z.sd = 1'b0; z.ov = 1'b0; z.ent = '0;
        check_all(-1, z);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            ent_valid   = tbl[i].ev;
            ent_data    = tbl[i].ed;
            init_ready  = tbl[i].ir;
            do_reseed   = tbl[i].rs;
            next_ready  = tbl[i].nr;
            random_bits = tbl[i].rb;
            ks_ready    = tbl[i].kr;
            @(posedge clk);
            #1;
            check_all(i, tbl[i]);
        end

        // Two words captured while still in S_SEED, then idx advanced to 3.
        @(negedge clk);
        drive_idle();
        next_ready  = 1'b1;
        random_bits = rb1;
        @(negedge clk);
        random_bits = rb2;
        @(negedge clk);
        next_ready  = 1'b0;
        random_bits = '0;
        ks_ready    = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        ks_ready = 1'b0;
        check("mid_ks_valid", 100, 256'(ks_valid), 256'(1'b1));
        check("mid_ks_word",  100, 256'(ks_word),  256'(32'h4));
        check("mid_overflow", 100, 256'(overflow), 256'(1'b1));
        check("mid_seeded",   100, 256'(seeded),   256'(1'b1));

        #2;
        reset_n = 1'b0;
        #1;
        check_all(101, z);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        z.er = 1'b1;
        check_all(102, z);

        @(negedge clk);
        ent_valid = 1'b1;
        ent_data  = ed3;
        @(posedge clk);
        #1;
        ent_valid = 1'b0;
        z.er = 1'b0; z.up = 1'b1; z.ent = ed3;
        check_all(103, z);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_applied, n_miscmp);
        $finish;
    end

endmodule
